// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences each instruction over
// the shared-memory datapath, with memory handshake, illegal-op trap and retire counter.
module mc_cu #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32,
    parameter int MEM_HS  = 1,
    parameter int TRAP_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [1:0]         PCSource,
    output logic               ImmExt,
    output logic               Memrhalf,
    output logic               Memrbyte,
    output logic               MemExt,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instr_cnt
);
    localparam logic [3:0] S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,
                           S_MEMADR = 4'd3,  S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,
                           S_MEMWR  = 4'd6,  S_EXEC_R = 4'd7,  S_EXEC_I = 4'd8,
                           S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
                           S_TRAP   = 4'd12;

    localparam logic [5:0] OP_R  = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_LH  = 6'b100001, OP_LHU  = 6'b100101,
                           OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_SW   = 6'b101011,
                           OP_SH = 6'b101001, OP_SB  = 6'b101000, OP_BEQ  = 6'b000100,
                           OP_J  = 6'b000010;

    localparam logic [ALUOP_W-1:0] AOP_ADD = ALUOP_W'(3'b000), AOP_SUB = ALUOP_W'(3'b001),
                                   AOP_OR  = ALUOP_W'(3'b010), AOP_FN  = ALUOP_W'(3'b111);

    function automatic logic is_load(input logic [5:0] o);
        return (o == OP_LW) || (o == OP_LH) || (o == OP_LHU) || (o == OP_LB) || (o == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] o);
        return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy;

    assign rdy       = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign state     = state_q;
    assign instr_cnt = cnt_q;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_load(op) || is_store(op))        state_d = S_MEMADR;
                else if (op == OP_R)                    state_d = S_EXEC_R;
                else if (op == OP_ADDI || op == OP_ORI) state_d = S_EXEC_I;
                else if (op == OP_BEQ)                  state_d = S_BRANCH;
                else if (op == OP_J)                    state_d = S_JUMP;
                else                                    state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
            end
            S_MEMADR: state_d = is_load(op_q) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Retirement = any arrival in FETCH except the initial IDLE hop and fetch stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= op;
            if (state_d == S_FETCH && state_q != S_IDLE && state_q != S_FETCH)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = 2'b00;
        PCSource    = 2'b00;
        ImmExt      = 1'b0;
        Memrhalf    = 1'b0;
        Memrbyte    = 1'b0;
        MemExt      = 1'b0;
        ALUop       = AOP_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            S_DECODE: begin
                ALUsrcB = 2'b11;
                ImmExt  = 1'b1;
            end
            S_MEMADR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                ImmExt  = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUsrcA = 1'b1;
                ALUop   = AOP_FN;
            end
            S_EXEC_I: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                ImmExt  = (op_q == OP_ADDI);
                ALUop   = (op_q == OP_ORI) ? AOP_OR : AOP_ADD;
            end
            S_ALUWB: begin
                // ALU selects stay as in EXEC so ALUOut's source is stable during writeback.
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_R);
                ALUsrcA  = 1'b1;
                if (op_q == OP_R) begin
                    ALUop = AOP_FN;
                end else begin
                    ALUsrcB = 2'b10;
                    ImmExt  = (op_q == OP_ADDI);
                    ALUop   = (op_q == OP_ORI) ? AOP_OR : AOP_ADD;
                end
            end
            S_BRANCH: begin
                ALUsrcA     = 1'b1;
                ALUop       = AOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
        if (state_q == S_MEMRD || state_q == S_MEMWB || state_q == S_MEMWR) begin
            Memrhalf = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
            Memrbyte = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
            MemExt   = (op_q == OP_LH) || (op_q == OP_LB);
        end
    end
endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: per-instruction state paths derived from the instruction class,
// per-state expected control vectors, and a retired-instruction count model.
module tb_mc_cu;
    localparam logic [5:0] OP_R  = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_LH  = 6'b100001, OP_LHU  = 6'b100101,
                           OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_SW   = 6'b101011,
                           OP_SH = 6'b101001, OP_SB  = 6'b101000, OP_BEQ  = 6'b000100,
                           OP_J  = 6'b000010, OP_BAD = 6'b111111;
    localparam logic [5:0] LEGAL [13] = '{OP_R, OP_ORI, OP_ADDI, OP_LW, OP_LH, OP_LHU,
                                          OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_J};

    typedef struct packed {
        logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
        logic       RegWrite, RegDst, MemtoReg, ALUsrcA;
        logic [1:0] ALUsrcB, PCSource;
        logic       ImmExt, Memrhalf, Memrbyte, MemExt;
        logic [2:0] ALUop;
        logic       illegal;
    } outs_t;

    logic clk = 1'b0;
    logic rst, rst2, mem_ready, mem_ready2;
    logic [5:0] op, op2;
    always #5 clk = ~clk;

    logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
    logic ALUsrcA, ImmExt, Memrhalf, Memrbyte, MemExt, illegal;
    logic [1:0] ALUsrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;
    logic [31:0] instr_cnt;
    logic PCWrite2, PCWriteCond2, IorD2, IRWrite2, MemRead2, MemWrite2, RegWrite2, RegDst2, MemtoReg2;
    logic ALUsrcA2, ImmExt2, Memrhalf2, Memrbyte2, MemExt2, illegal2;
    logic [1:0] ALUsrcB2, PCSource2;
    logic [2:0] ALUop2;
    logic [3:0] state2;
    logic [1:0] instr_cnt2;
    outs_t o1, o2;

    assign o1 = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite, RegDst,
                 MemtoReg, ALUsrcA, ALUsrcB, PCSource, ImmExt, Memrhalf, Memrbyte, MemExt, ALUop, illegal};
    assign o2 = {PCWrite2, PCWriteCond2, IorD2, IRWrite2, MemRead2, MemWrite2, RegWrite2, RegDst2,
                 MemtoReg2, ALUsrcA2, ALUsrcB2, PCSource2, ImmExt2, Memrhalf2, Memrbyte2, MemExt2, ALUop2, illegal2};

    mc_cu dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .PCSource(PCSource),
        .ImmExt(ImmExt), .Memrhalf(Memrhalf), .Memrbyte(Memrbyte), .MemExt(MemExt),
        .ALUop(ALUop), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
    );

    mc_cu #(.ALUOP_W(3), .CNT_W(2), .MEM_HS(0), .TRAP_EN(0)) dut2 (
        .clk(clk), .rst(rst2), .op(op2), .mem_ready(mem_ready2),
        .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .IorD(IorD2), .IRWrite(IRWrite2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .RegWrite(RegWrite2), .RegDst(RegDst2),
        .MemtoReg(MemtoReg2), .ALUsrcA(ALUsrcA2), .ALUsrcB(ALUsrcB2), .PCSource(PCSource2),
        .ImmExt(ImmExt2), .Memrhalf(Memrhalf2), .Memrbyte(Memrbyte2), .MemExt(MemExt2),
        .ALUop(ALUop2), .illegal(illegal2), .state(state2), .instr_cnt(instr_cnt2)
    );

    int nchk = 0, npass = 0, nfail = 0;
    int model_cnt = 0, model_cnt2 = 0;
    int path_st[$];
    bit path_rdy[$];

    function automatic bit is_ld(input logic [5:0] o);
        return o inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction
    function automatic bit is_st(input logic [5:0] o);
        return o inside {OP_SW, OP_SH, OP_SB};
    endfunction

    // Control vector each state should present, given the instruction being run.
    function automatic outs_t exp_out(input int st, input logic [5:0] o, input bit rdy);
        outs_t r = '0;
        bit imm_i = (o != OP_R);
        case (st)
            1: begin r.MemRead = 1; r.ALUsrcB = 2'b01; r.IRWrite = rdy; r.PCWrite = rdy; end
            2: begin r.ALUsrcB = 2'b11; r.ImmExt = 1; end
            3: begin r.ALUsrcA = 1; r.ALUsrcB = 2'b10; r.ImmExt = 1; end
            4: begin r.MemRead = 1; r.IorD = 1; end
            5: begin r.RegWrite = 1; r.MemtoReg = 1; end
            6: begin r.MemWrite = 1; r.IorD = 1; end
            7: begin r.ALUsrcA = 1; r.ALUop = 3'b111; end
            8, 9: begin
                r.ALUsrcA = 1;
                if (st == 9) begin r.RegWrite = 1; r.RegDst = !imm_i; end
                if (imm_i) begin
                    r.ALUsrcB = 2'b10;
                    r.ImmExt  = (o == OP_ADDI);
                    r.ALUop   = (o == OP_ORI) ? 3'b010 : 3'b000;
                end else r.ALUop = 3'b111;
            end
            10: begin r.ALUsrcA = 1; r.ALUop = 3'b001; r.PCWriteCond = 1; r.PCSource = 2'b01; end
            11: begin r.PCWrite = 1; r.PCSource = 2'b10; end
            12: r.illegal = 1;
            default: ;
        endcase
        if (st inside {4, 5, 6}) begin
            r.Memrhalf = o inside {OP_LH, OP_LHU, OP_SH};
            r.Memrbyte = o inside {OP_LB, OP_LBU, OP_SB};
            r.MemExt   = o inside {OP_LH, OP_LB};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input bit r);
        path_st.push_back(s);
        path_rdy.push_back(r);
    endtask

    // State path of one instruction: fst/mst = cycles mem_ready stays low in FETCH / memory.
    task automatic build(input logic [5:0] o, input int fst, input int mst, input bit trap_en);
        path_st.delete();
        path_rdy.delete();
        for (int i = 0; i <= fst; i++) push(1, i == fst);
        push(2, 1'($urandom));
        if (is_ld(o)) begin
            push(3, 1'($urandom));
            for (int i = 0; i <= mst; i++) push(4, i == mst);
            push(5, 1'($urandom));
        end else if (is_st(o)) begin
            push(3, 1'($urandom));
            for (int i = 0; i <= mst; i++) push(6, i == mst);
        end else if (o == OP_R) begin
            push(7, 1'($urandom)); push(9, 1'($urandom));
        end else if (o == OP_ADDI || o == OP_ORI) begin
            push(8, 1'($urandom)); push(9, 1'($urandom));
        end else if (o == OP_BEQ) push(10, 1'($urandom));
        else if (o == OP_J) push(11, 1'($urandom));
        else if (trap_en) push(12, 1'($urandom));
    endtask

    // One cycle on dut: op is only meaningful up to DECODE, garbage afterwards.
    task automatic step(input int st, input bit rdy, input logic [5:0] o);
        op = (st <= 2) ? o : 6'($urandom);
        mem_ready = rdy;
        #1;
        chk($sformatf("state(op=%b,st=%0d)", o, st), 64'(state), 64'(st));
        chk($sformatf("outs(op=%b,st=%0d)", o, st), 64'(o1), 64'(exp_out(st, o, rdy)));
        @(posedge clk); #1;
    endtask

    task automatic run1(input logic [5:0] o, input int fst, input int mst);
        build(o, fst, mst, 1'b1);
        foreach (path_st[i]) step(path_st[i], path_rdy[i], o);
        if (o inside {LEGAL}) begin
            model_cnt++;
            chk($sformatf("instr_cnt(op=%b)", o), 64'(instr_cnt), 64'(model_cnt));
        end
    endtask

    task automatic run2(input logic [5:0] o);
        build(o, 0, 0, 1'b0);
        foreach (path_st[i]) begin
            op2 = (path_st[i] <= 2) ? o : 6'($urandom);
            #1;
            chk($sformatf("dut2 state(op=%b)", o), 64'(state2), 64'(path_st[i]));
            chk($sformatf("dut2 outs(op=%b)", o), 64'(o2), 64'(exp_out(path_st[i], o, 1'b1)));
            @(posedge clk); #1;
        end
        model_cnt2 = (model_cnt2 + 1) % 4;
        chk($sformatf("dut2 instr_cnt(op=%b)", o), 64'(instr_cnt2), 64'(model_cnt2));
    endtask

    task automatic do_reset();
        rst = 1'b1; op = '0; mem_ready = 1'b0;
        #1;
        model_cnt = 0;
        chk("reset state", 64'(state), 64'd0);
        chk("reset outs", 64'(o1), 64'd0);
        chk("reset instr_cnt", 64'(instr_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle after release", 64'(state), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst2 = 1'b1; op2 = '0; mem_ready2 = 1'b0;
        do_reset();
        run1(OP_LW, 0, 0);
        run1(OP_SB, 0, 3);
        do_reset();
        run1(OP_R, 0, 0);
        run1(OP_ORI, 0, 0);
        run1(OP_BEQ, 0, 0);
        run1(OP_J, 0, 0);
        run1(OP_ADDI, 2, 0);
        for (int n = 0; n < 40; n++)
            run1(LEGAL[$urandom_range(0, 12)], $urandom_range(0, 2), $urandom_range(0, 2));

        // Trap holds until reset and retires nothing.
        run1(OP_BAD, 1, 0);
        for (int n = 0; n < 4; n++) begin
            mem_ready = 1'($urandom); op = 6'($urandom);
            #1;
            chk("trap state", 64'(state), 64'd12);
            chk("trap outs", 64'(o1), 64'(exp_out(12, OP_BAD, 1'b0)));
            chk("trap instr_cnt", 64'(instr_cnt), 64'(model_cnt));
            @(posedge clk); #1;
        end

        // Asynchronous reset landing in the middle of a MEMRD stall.
        do_reset();
        run1(OP_LH, 0, 0);
        step(1, 1'b1, OP_LW);
        step(2, 1'b1, OP_LW);
        step(3, 1'b0, OP_LW);
        step(4, 1'b0, OP_LW);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", 64'(state), 64'd0);
        chk("async rst outs", 64'(o1), 64'd0);
        chk("async rst instr_cnt", 64'(instr_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        model_cnt = 0;
        run1(OP_SH, 0, 1);

        // No-handshake, no-trap, 2-bit counter variant.
        rst2 = 1'b0;
        #1;
        chk("dut2 idle", 64'(state2), 64'd0);
        @(posedge clk); #1;
        run2(OP_LW);
        run2(OP_SW);
        run2(OP_BAD);
        run2(OP_J);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/mc_cu.md
Name: mc_cu

Overview:
Multi-cycle successor to the single-cycle MIPS control unit. It covers the same instruction set: R-type, ori, addi, lw/lh/lhu/lb/lbu, sw/sh/sb, beq, j. A Moore FSM sequences each instruction over 3-5 states and drives the shared-memory multi-cycle datapath. It adds a memory ready handshake, illegal-opcode trapping and a retired-instruction counter.

Parameters:
ALUOP_W, 3, ALUop width; encodings 000 add, 001 sub, 010 or, 111 funct-decoded.
CNT_W, 32, instr_cnt width.
MEM_HS, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
TRAP_EN, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode retires as NOP.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
op  in  6  IR[31:26]; valid from DECODE onward.
mem_ready  in  1  memory completes the current read/write this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if ALU zero (beq).
IorD  out  1  0 = PC address, 1 = ALUOut address.
IRWrite  out  1  load IR.
MemRead, MemWrite  out  1  memory strobes.
RegWrite, RegDst, MemtoReg  out  1  register-file controls; RegDst 1 = rd.
ALUsrcA  out  1  0 = PC, 1 = A.
ALUsrcB  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
ImmExt  out  1  1 = sign-extend, 0 = zero-extend.
Memrhalf, Memrbyte, MemExt  out  1  load/store size; MemExt 1 = sign-extend load.
ALUop  out  ALUOP_W  ALU operation.
illegal  out  1  TRAP state indicator.
state  out  4  current state, for debug.
instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, EXEC_I 8, ALUWB 9, BRANCH 10, JUMP 11, TRAP 12. Codes 13-15 go to IDLE.
- rst=1 forces IDLE, op_q=0 and instr_cnt=0 immediately, including mid-instruction. In IDLE every output is 0 (state=0). IDLE -> FETCH on the first clock after reset is released.
- FETCH outputs: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=000, PCSource=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: latch op into op_q. Outputs ALUsrcA=0, ALUsrcB=11, ALUop=000, ImmExt=1 (branch target).
- Next state from DECODE:
  - loads/stores -> MEMADR
  - R-type -> EXEC_R
  - addi/ori -> EXEC_I
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode -> TRAP if TRAP_EN=1, else FETCH
- All states after DECODE decode from op_q only.
- MEMADR: ALUsrcA=1, ALUsrcB=10, ImmExt=1, ALUop=000. Next state MEMRD for loads, MEMWR for stores.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1 and IorD=1, held until mem_ready, then FETCH.
- Size flags in MEMRD, MEMWB and MEMWR:
  - Memrhalf=1 for lh/lhu/sh.
  - Memrbyte=1 for lb/lbu/sb.
  - MemExt=1 for lh/lb only.
- EXEC_R: ALUsrcA=1, ALUsrcB=00, ALUop=111 -> ALUWB. EXEC_I: ALUsrcA=1, ALUsrcB=10; addi uses ImmExt=1 and ALUop=000, ori uses ImmExt=0 and ALUop=010 -> ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. RegDst=1 if op_q is R-type, else 0. Hold the previous ALU selects. Next state FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=001, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- TRAP: illegal=1, every other strobe 0. Held until rst.
- Any output not listed for a state is 0.
- instr_cnt increments by 1 on each transition into FETCH from a state other than IDLE or FETCH, including NOP retirements. It wraps modulo 2^CNT_W.
- With MEM_HS=0 every wait is exactly one cycle. Instruction latencies: lw 5, sw 4, R-type/I-type 4, beq 3, j 3 cycles.

Test Plan:
- Reset then lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 in MEMWB; instr_cnt=1.
- sb (op=101000) with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and Memrbyte=1 held 4 cycles; FETCH on the cycle after mem_ready=1; MemExt=0.
- R-type, ori (001101), beq (000100), j (000010) back-to-back:
  - ori: ImmExt=0, ALUop=010.
  - beq: ALUop=001, PCWriteCond=1.
  - j: PCSource=10.
  - instr_cnt=4.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH -> IRWrite=0 and PCWrite=0 while stalled; both 1 on the cycle mem_ready=1.
- Illegal op=111111: TRAP_EN=1 -> illegal=1, state=12 until rst, instr_cnt unchanged. TRAP_EN=0 -> returns to FETCH, instr_cnt +1.
- rst asserted in MEMRD -> state=0 and all outputs 0 immediately, without waiting for a clock edge. instr_cnt wrap check with CNT_W=2: 4 instructions -> instr_cnt=0.
